up_run_ctrl: RTL and testbench

Run controller for the 8-bit accumulator microprocessor. It shares the 32-byte program memory between a host loader port and the CPU. It sequences CPU reset, free-run, single-step and stop through a clock-enable, and reports cycle count and halt/timeout status. It sits between the board-level host interface and the top-level CPU, driving the CPU's reset and clock enable and the memory write-port mux.

---
 rtl/up_pkg.sv | 17 +
 rtl/up_load_port.sv | 40 ++++
 rtl/up_run_ctrl.sv | 170 +++++++++++++++++
 tb/tb_up_run_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/up_pkg.sv
// Shared definitions for the up_* accumulator-processor blocks:
// run-controller state encodings and default memory geometry.
package up_pkg;

    localparam int UP_ADDR_W = 5;
    localparam int UP_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PRESET = 3'd2,
        ST_RUN    = 3'd3,
        ST_STEP   = 3'd4,
        ST_HALTED = 3'd5
    } run_state_e;

endpackage

// File: rtl/up_load_port.sv
// Host load port: captures each accepted ld_valid/ld_ready beat and
// replays it as a one-cycle memory write on the following cycle.
// Address/data hold their last value between writes.
module up_load_port
    import up_pkg::*;
#(
    parameter int ADDR_W = UP_ADDR_W,
    parameter int DATA_W = UP_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    input  logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data
);

    logic accept;

    assign accept = ld_valid & ld_ready;

    // Register accepted beats; reset drops any write still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            mem_wr <= accept;
            if (accept) begin
                mem_addr <= ld_addr;
                mem_data <= ld_data;
            end
        end
    end

endmodule

// File: rtl/up_run_ctrl.sv
// Run controller for the 8-bit accumulator CPU: arbitrates the program
// memory write port between host loader and CPU, sequences CPU reset,
// free-run, single-step and stop via cpu_rst_n/cpu_clk_en, and counts
// enabled CPU cycles.
// Optional watchdog: define UP_RUN_CTRL_WDOG_EN to halt RUN once
// cycle_cnt reaches MAX_CYCLES and flag timeout.
module up_run_ctrl
    import up_pkg::*;
#(
    parameter int          ADDR_W     = UP_ADDR_W,
    parameter int          DATA_W     = UP_DATA_W,
    parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              start,
    input  logic              step,
    input  logic              stop,
    input  logic              cpu_halt,
    output logic              cpu_rst_n,
    output logic              cpu_clk_en,
    output logic              mem_sel,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic [2:0]        state,
    output logic [15:0]       cycle_cnt,
    output logic              timeout
);

    run_state_e cur_state;
    run_state_e nxt_state;
    logic       step_mode;      // PRESET was entered by step, so go to STEP after it
    logic       nxt_step_mode;
    logic       ready_en;       // keeps ld_ready low while reset is asserted
    logic       wdog_hit;
    logic       enter_preset;

    assign state        = cur_state;
    assign enter_preset = (nxt_state == ST_PRESET);

    up_load_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_load_port (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_data (mem_data)
    );

`ifdef UP_RUN_CTRL_WDOG_EN
    // Fire on the edge that counts the MAX_CYCLES-th enabled cycle, so the
    // CPU stops with cycle_cnt exactly at the limit.
    assign wdog_hit = (cur_state == ST_RUN) && (cycle_cnt >= (MAX_CYCLES - 16'd1));

    // Sticky timeout flag, cleared when a new run is prepared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout <= 1'b0;
        end else if (enter_preset) begin
            timeout <= 1'b0;
        end else if (wdog_hit) begin
            timeout <= 1'b1;
        end
    end
`else
    // No watchdog: the limit has no effect on this build.
    logic unused_max_cycles;
    assign unused_max_cycles = ^MAX_CYCLES;
    assign wdog_hit          = 1'b0;
    assign timeout           = 1'b0;
`endif

    // State register plus step-mode and ready-enable flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= ST_IDLE;
            step_mode <= 1'b0;
            ready_en  <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            step_mode <= nxt_step_mode;
            ready_en  <= 1'b1;
        end
    end

    // Next-state selection and per-state CPU/memory control outputs.
    always_comb begin
        nxt_state     = cur_state;
        nxt_step_mode = step_mode;
        cpu_rst_n     = 1'b0;
        cpu_clk_en    = 1'b0;
        mem_sel       = 1'b0;
        ld_ready      = 1'b0;
        case (cur_state)
            ST_IDLE: begin
                mem_sel  = 1'b1;
                ld_ready = ready_en;
                if (ld_valid) begin
                    nxt_state = ST_LOAD;
                end else if (start) begin
                    nxt_state     = ST_PRESET;
                    nxt_step_mode = 1'b0;
                end else if (step) begin
                    nxt_state     = ST_PRESET;
                    nxt_step_mode = 1'b1;
                end
            end
            ST_LOAD: begin
                mem_sel  = 1'b1;
                ld_ready = ready_en;
                // Stay until the last captured beat has been written.
                if (!ld_valid && !mem_wr) begin
                    nxt_state = ST_IDLE;
                end
            end
            ST_PRESET: begin
                nxt_state = step_mode ? ST_STEP : ST_RUN;
            end
            ST_RUN: begin
                cpu_rst_n  = 1'b1;
                cpu_clk_en = 1'b1;
                if (stop || cpu_halt || wdog_hit) begin
                    nxt_state = ST_HALTED;
                end
            end
            ST_STEP: begin
                cpu_rst_n  = 1'b1;
                cpu_clk_en = 1'b1;
                nxt_state  = ST_HALTED;
            end
            ST_HALTED: begin
                cpu_rst_n = 1'b1;
                if (ld_valid) begin
                    nxt_state = ST_LOAD;
                end else if (start) begin
                    nxt_state     = ST_PRESET;
                    nxt_step_mode = 1'b0;
                end else if (step) begin
                    nxt_state = ST_STEP;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase
    end

    // Saturating count of enabled CPU cycles, cleared on entry to PRESET.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
        end else if (enter_preset) begin
            cycle_cnt <= '0;
        end else if (cpu_clk_en && (cycle_cnt != 16'hFFFF)) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_up_run_ctrl.sv
// Directed bench for up_run_ctrl: load, run/halt, single-step, command
// priority, watchdog (when UP_RUN_CTRL_WDOG_EN is defined) and
// asynchronous reset mid-operation.
module tb_up_run_ctrl;

    localparam int S_IDLE   = 0;
    localparam int S_LOAD   = 1;
    localparam int S_PRESET = 2;
    localparam int S_RUN    = 3;
    localparam int S_STEP   = 4;
    localparam int S_HALTED = 5;

    logic        clk;
    logic        rst_n;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        start;
    logic        step;
    logic        stop;
    logic        cpu_halt;
    logic        cpu_rst_n;
    logic        cpu_clk_en;
    logic        mem_sel;
    logic        mem_wr;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_data;
    logic [2:0]  state;
    logic [15:0] cycle_cnt;
    logic        timeout;

    int n_vec = 0;
    int n_err = 0;

    up_run_ctrl #(
        .ADDR_W     (5),
        .DATA_W     (8),
        .MAX_CYCLES (16'd20)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .start      (start),
        .step       (step),
        .stop       (stop),
        .cpu_halt   (cpu_halt),
        .cpu_rst_n  (cpu_rst_n),
        .cpu_clk_en (cpu_clk_en),
        .mem_sel    (mem_sel),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .state      (state),
        .cycle_cnt  (cycle_cnt),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input int st, input logic crst,
                           input logic en, input logic sel, input logic rdy);
        chk({tag, "_state"}, 32'(state), 32'(st));
        chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(crst));
        chk({tag, "_cpu_clk_en"}, 32'(cpu_clk_en), 32'(en));
        chk({tag, "_mem_sel"}, 32'(mem_sel), 32'(sel));
        chk({tag, "_ld_ready"}, 32'(ld_ready), 32'(rdy));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b1;
        ld_valid = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        start    = 1'b0;
        step     = 1'b0;
        stop     = 1'b0;
        cpu_halt = 1'b0;

        // reset state
        #2 rst_n = 1'b0;
        #1;
        chk_ctl("rst", S_IDLE, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_mem_wr", 32'(mem_wr), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_data", 32'(mem_data), 0);
        chk("rst_cnt", 32'(cycle_cnt), 0);
        chk("rst_timeout", 32'(timeout), 0);
        ld_valid = 1'b1; ld_addr = 5'h1F; ld_data = 8'hFF;
        tick(); tick();
        chk("rst_hold_rdy", 32'(ld_ready), 0);
        chk("rst_hold_wr", 32'(mem_wr), 0);
        ld_valid = 1'b0;
        #6 rst_n = 1'b1;
        tick();
        chk_ctl("idle", S_IDLE, 1'b0, 1'b0, 1'b1, 1'b1);

        // three back-to-back load beats
        ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 8'hA0;
        tick();
        chk("ld0_state", 32'(state), S_LOAD);
        chk("ld0_wr", 32'(mem_wr), 1);
        chk("ld0_addr", 32'(mem_addr), 0);
        chk("ld0_data", 32'(mem_data), 32'hA0);
        ld_addr = 5'd1; ld_data = 8'h3F;
        tick();
        chk("ld1_wr", 32'(mem_wr), 1);
        chk("ld1_addr", 32'(mem_addr), 1);
        chk("ld1_data", 32'(mem_data), 32'h3F);
        ld_addr = 5'd2; ld_data = 8'hE0;
        tick();
        chk("ld2_wr", 32'(mem_wr), 1);
        chk("ld2_addr", 32'(mem_addr), 2);
        chk("ld2_data", 32'(mem_data), 32'hE0);
        ld_valid = 1'b0;
        tick();
        chk("ld_end_state", 32'(state), S_LOAD);
        chk("ld_end_wr", 32'(mem_wr), 0);
        chk("ld_hold_addr", 32'(mem_addr), 2);
        chk("ld_hold_data", 32'(mem_data), 32'hE0);
        tick();
        chk("ld_back_idle", 32'(state), S_IDLE);

        // start: PRESET then RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_ctl("preset", S_PRESET, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("preset_cnt", 32'(cycle_cnt), 0);
        tick();
        chk_ctl("run", S_RUN, 1'b1, 1'b1, 1'b0, 1'b0);

        // halt after 10 enabled cycles
        repeat (9) tick();
        chk("run9_cnt", 32'(cycle_cnt), 9);
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        chk_ctl("halt", S_HALTED, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("halt_cnt", 32'(cycle_cnt), 10);
        tick();
        chk("halt_frozen_cnt", 32'(cycle_cnt), 10);

        // HALTED -> LOAD: beat not taken in HALTED, CPU back in reset
        ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 8'h33;
        tick();
        ld_valid = 1'b0;
        chk_ctl("h2load", S_LOAD, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("h2load_wr", 32'(mem_wr), 0);
        chk("h2load_addr", 32'(mem_addr), 2);
        tick();
        chk("h2load_idle", 32'(state), S_IDLE);

        // single step from IDLE, then two steps from HALTED
        step = 1'b1;
        tick();
        step = 1'b0;
        chk_ctl("st_preset", S_PRESET, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("st_preset_cnt", 32'(cycle_cnt), 0);
        tick();
        chk_ctl("st1", S_STEP, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_ctl("st1_halt", S_HALTED, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("st1_cnt", 32'(cycle_cnt), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_ignored", 32'(state), S_HALTED);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk_ctl("st2", S_STEP, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("st2_cnt", 32'(cycle_cnt), 2);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("st3_rst_n", 32'(cpu_rst_n), 1);
        tick();
        chk("st3_state", 32'(state), S_HALTED);
        chk("st3_cnt", 32'(cycle_cnt), 3);

        // HALTED priority: ld_valid wins over start and step
        ld_valid = 1'b1; start = 1'b1; step = 1'b1; ld_addr = 5'd5; ld_data = 8'h55;
        tick();
        start = 1'b0; step = 1'b0;
        chk("hprio_state", 32'(state), S_LOAD);
        chk("hprio_wr", 32'(mem_wr), 0);
        start = 1'b1;
        tick();
        chk("ld_start_ign", 32'(state), S_LOAD);
        chk("hprio_beat_wr", 32'(mem_wr), 1);
        chk("hprio_beat_addr", 32'(mem_addr), 5);
        chk("hprio_beat_data", 32'(mem_data), 32'h55);
        ld_valid = 1'b0; start = 1'b0;
        tick();
        tick();
        chk("hprio_idle", 32'(state), S_IDLE);

        // IDLE: start with ld_valid goes to LOAD and start is dropped
        ld_valid = 1'b1; start = 1'b1; ld_addr = 5'd7; ld_data = 8'h77;
        tick();
        ld_valid = 1'b0; start = 1'b0;
        chk("iprio_state", 32'(state), S_LOAD);
        chk("iprio_addr", 32'(mem_addr), 7);
        tick();
        tick();
        chk("iprio_idle", 32'(state), S_IDLE);
        tick();
        chk("iprio_dropped", 32'(state), S_IDLE);

        // RUN: step ignored; stop with cpu_halt halts in one cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("run_step_ign", 32'(state), S_RUN);
        chk("run_step_cnt", 32'(cycle_cnt), 1);
        stop = 1'b1; cpu_halt = 1'b1;
        tick();
        stop = 1'b0; cpu_halt = 1'b0;
        chk("both_state", 32'(state), S_HALTED);
        chk("both_cnt", 32'(cycle_cnt), 2);

        // restart from HALTED, stop alone
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_state", 32'(state), S_PRESET);
        chk("restart_cnt", 32'(cycle_cnt), 0);
        tick(); tick(); tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_state", 32'(state), S_HALTED);
        chk("stop_cnt", 32'(cycle_cnt), 3);

        // free run without halt
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
`ifdef UP_RUN_CTRL_WDOG_EN
        repeat (19) tick();
        chk("wd19_state", 32'(state), S_RUN);
        chk("wd19_timeout", 32'(timeout), 0);
        tick();
        chk("wd_state", 32'(state), S_HALTED);
        chk("wd_timeout", 32'(timeout), 1);
        chk("wd_cnt", 32'(cycle_cnt), 20);
        tick();
        chk("wd_sticky", 32'(timeout), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("wd_clr_timeout", 32'(timeout), 0);
        chk("wd_clr_cnt", 32'(cycle_cnt), 0);
        tick();
        chk("wd_rerun", 32'(state), S_RUN);
`else
        repeat (25) tick();
        chk("nowd_state", 32'(state), S_RUN);
        chk("nowd_cnt", 32'(cycle_cnt), 25);
        chk("nowd_timeout", 32'(timeout), 0);
`endif

        // asynchronous reset during RUN
        tick();
        rst_n = 1'b0;
        #1;
        chk_ctl("rrun", S_IDLE, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rrun_cnt", 32'(cycle_cnt), 0);
        chk("rrun_timeout", 32'(timeout), 0);
        #2 rst_n = 1'b1;
        tick();
        chk_ctl("rrun_rel", S_IDLE, 1'b0, 1'b0, 1'b1, 1'b1);

        // asynchronous reset while a load write is in flight
        ld_valid = 1'b1; ld_addr = 5'd9; ld_data = 8'h99;
        tick();
        chk("rld_wr", 32'(mem_wr), 1);
        chk("rld_addr", 32'(mem_addr), 9);
        rst_n = 1'b0;
        #1;
        chk("rld_wr_drop", 32'(mem_wr), 0);
        chk("rld_addr_rst", 32'(mem_addr), 0);
        chk("rld_data_rst", 32'(mem_data), 0);
        chk("rld_state", 32'(state), S_IDLE);
        ld_valid = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        chk("rld_after_wr0", 32'(mem_wr), 0);
        tick();
        chk("rld_after_wr1", 32'(mem_wr), 0);
        chk("rld_after_state", 32'(state), S_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
